e_mdu: RTL and testbench

//   Multiply/divide unit of the E stage in the 5-stage MIPS pipeline. It runs

---
 rtl/e_mdu_if.sv | 21 ++
 rtl/e_mdu.sv | 139 +++++++++++++
 tb/tb_e_mdu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        req;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, mdu_op, a, b, req,
      input  busy, hi, lo
   );

   modport slave (
      input  start, mdu_op, a, b, req,
      output busy, hi, lo
   );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/multu/div/divu, HI/LO
// registers, and mthi/mtlo writes. The 64-bit result is computed at issue and
// parked in temp registers; HI/LO only change on the final busy edge.
module e_mdu #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave m
);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   localparam logic [3:0] MULT_N = 4'(MULT_CYC);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

   state_e      state, next_state;
   op_e         op;
   logic [3:0]  cnt;
   logic [31:0] hi_q, lo_q;
   logic [31:0] temp_hi, temp_lo;
   logic        div_zero;

   logic        issue, commit, mt_en, is_div;
   logic [63:0] prod_s, prod_u, result;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

   assign op     = op_e'(m.mdu_op);
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign prod_s = {{32{m.a[31]}}, m.a} * {{32{m.b[31]}}, m.b};
   assign prod_u = {32'd0, m.a} * {32'd0, m.b};

   // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0;
   // a zero divisor is replaced by 1 only to keep the divider defined (commit is skipped).
   always_comb begin
      neg_a = (op == OP_DIV) && m.a[31];
      neg_b = (op == OP_DIV) && m.b[31];
      mag_a = neg_a ? (32'd0 - m.a) : m.a;
      mag_b = neg_b ? (32'd0 - m.b) : m.b;
      div_b = (mag_b == '0) ? 32'd1 : mag_b;
      uq    = mag_a / div_b;
      ur    = mag_a % div_b;
      quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
      rem   = neg_a ? (32'd0 - ur) : ur;
   end

   // Select the 64-bit {hi,lo} result for the op being issued.
   always_comb begin
      result = '0;
      case (op)
         OP_MULT:         result = prod_s;
         OP_MULTU:        result = prod_u;
         OP_DIV, OP_DIVU: result = {rem, quo};
         default:         result = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state, issue and commit decode; req masks every new issue.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      commit     = 1'b0;
      mt_en      = 1'b0;
      case (state)
         S_IDLE: begin
            if (m.start && !m.req) begin
               if (op == OP_MULT || op == OP_MULTU || is_div) begin
                  issue      = 1'b1;
                  next_state = S_BUSY;
               end
               mt_en = (op == OP_MTHI) || (op == OP_MTLO);
            end
         end
         S_BUSY: begin
            if (cnt == 4'd1) begin
               commit     = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath: capture result at issue, count down, commit to HI/LO, mthi/mtlo.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         temp_hi  <= '0;
         temp_lo  <= '0;
         cnt      <= '0;
         div_zero <= 1'b0;
      end else begin
         if (issue) begin
            temp_hi  <= result[63:32];
            temp_lo  <= result[31:0];
            cnt      <= is_div ? DIV_N : MULT_N;
            div_zero <= is_div && (m.b == '0);
         end else if (state == S_BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && !div_zero) begin
            hi_q <= temp_hi;
            lo_q <= temp_lo;
         end
         if (mt_en && op == OP_MTHI) hi_q <= m.a;
         if (mt_en && op == OP_MTLO) lo_q <= m.a;
      end
   end

   assign m.busy = (state == S_BUSY);
   assign m.hi   = hi_q;
   assign m.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: table of single ops plus hand-written sequences
// for req masking, start-while-busy and reset mid-operation.
module tb_e_mdu;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk   (clk),
      .reset (reset),
      .m     (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic        req;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cyc;
   } vec_t;

   vec_t vecs [18];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [31:0] prev_hi, prev_lo;
      int          n;
      logic        held;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mdu_op = v.op;
      bus.a      = v.a;
      bus.b      = v.b;
      bus.req    = v.req;
      prev_hi    = bus.hi;
      prev_lo    = bus.lo;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.mdu_op = 3'd0;
      bus.req    = 1'b0;
      n    = 0;
      held = 1'b1;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         if (bus.hi !== prev_hi || bus.lo !== prev_lo) held = 1'b0;
         @(posedge clk);
         #1;
      end
      chk($sformatf("v%0d busy cycles", idx), 32'(n), 32'(v.cyc));
      chk($sformatf("v%0d hold", idx), {31'd0, held}, 32'd1);
      chk($sformatf("v%0d hi", idx), bus.hi, v.exp_hi);
      chk($sformatf("v%0d lo", idx), bus.lo, v.exp_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      logic bad;

      vecs[0]  = '{3'd1, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{3'd3, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{3'd4, 1'b0, 32'd7,        32'd2,        32'd1,        32'd3,        10};
      vecs[4]  = '{3'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
      vecs[5]  = '{3'd1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vecs[6]  = '{3'd3, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
      vecs[7]  = '{3'd2, 1'b0, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
      vecs[8]  = '{3'd5, 1'b0, 32'h1234,     32'd0,        32'h1234,     32'd0,        0};
      vecs[9]  = '{3'd6, 1'b0, 32'h5678,     32'd0,        32'h1234,     32'h5678,     0};
      vecs[10] = '{3'd3, 1'b0, 32'd5,        32'd0,        32'h1234,     32'h5678,     10};
      vecs[11] = '{3'd4, 1'b0, 32'd9,        32'd0,        32'h1234,     32'h5678,     10};
      vecs[12] = '{3'd1, 1'b1, 32'd3,        32'd4,        32'h1234,     32'h5678,     0};
      vecs[13] = '{3'd5, 1'b1, 32'h9999,     32'd0,        32'h1234,     32'h5678,     0};
      vecs[14] = '{3'd7, 1'b0, 32'd1,        32'd1,        32'h1234,     32'h5678,     0};
      vecs[15] = '{3'd0, 1'b0, 32'd1,        32'd1,        32'h1234,     32'h5678,     0};
      vecs[16] = '{3'd1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
      vecs[17] = '{3'd3, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.mdu_op = 3'd0;
      bus.a      = '0;
      bus.b      = '0;
      bus.req    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset lo", bus.lo, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // A: mult in flight, div attempt with req=1 at cycle 2 is dropped
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 3'd1; bus.a = 32'd3; bus.b = 32'd4; bus.req = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mdu_op = 3'd0;
      chk("A busy after issue", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mdu_op = 3'd3; bus.a = 32'd100; bus.b = 32'd5; bus.req = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mdu_op = 3'd0; bus.req = 1'b0;
      chk("A hi held", bus.hi, 32'h40000000 - 32'h40000000 + 32'hFFFFFFFF);
      wait_idle(n);
      chk("A busy cycles", 32'(n + 2), 32'd5);
      chk("A hi", bus.hi, 32'd0);
      chk("A lo", bus.lo, 32'd12);
      @(posedge clk); #1;
      chk("A no div issued", {31'd0, bus.busy}, 32'd0);
      chk("A lo kept", bus.lo, 32'd12);

      // B: divu in flight, start=1 mult at cycle 3 with req=0 is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mdu_op = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mdu_op = 3'd1; bus.a = 32'd3; bus.b = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mdu_op = 3'd0;
      wait_idle(n);
      chk("B busy cycles", 32'(n + 3), 32'd10);
      chk("B hi", bus.hi, 32'd2);
      chk("B lo", bus.lo, 32'd14);
      @(posedge clk); #1;
      chk("B no second op", {31'd0, bus.busy}, 32'd0);

      // C: reset during div aborts it, no later commit
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 3'd3; bus.a = 32'd50; bus.b = 32'd5;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mdu_op = 3'd0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("C busy after reset", {31'd0, bus.busy}, 32'd0);
      chk("C hi after reset", bus.hi, 32'd0);
      chk("C lo after reset", bus.lo, 32'd0);
      bad = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad = 1'b1;
      end
      chk("C no late commit", {31'd0, bad}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
